// File: rtl/jtag_bank_pkg.sv
// Shared constants for the virtual-JTAG register bank: default IR map,
// the run start command and the run FSM state codes.
package jtag_bank_pkg;

  localparam int IR_W_DEF       = 4;
  localparam int WR_IR_BASE_DEF = 6;
  localparam int CTRL_IR_DEF    = 5;
  localparam int STAT_IR_DEF    = 10;
  localparam int RES_IR_DEF     = 11;

  localparam logic [4:0] START_CODE_DEF = 5'b10101;

  // Run FSM state codes (IDLE/RESET/RUN/FINISHED)
  typedef logic [1:0] run_state_t;
  localparam run_state_t ST_IDLE     = 2'd0;
  localparam run_state_t ST_RESET    = 2'd1;
  localparam run_state_t ST_RUN      = 2'd2;
  localparam run_state_t ST_FINISHED = 2'd3;

endpackage

// File: rtl/jtag_shift_reg.sv
// One DR shift register: parallel capture on cdr, LSB-first shift on sdr,
// both only while the register is addressed by the current IR.
module jtag_shift_reg #(
  parameter int W = 8
) (
  input  logic         tck,
  input  logic         reset,
  input  logic         tdi,
  input  logic         sel,
  input  logic         cdr,
  input  logic         sdr,
  input  logic [W-1:0] load,
  output logic [W-1:0] sh
);

  // Capture wins over shift; tdi enters at the MSB so bit 0 leaves first
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      sh <= '0;
    end else if (sel && cdr) begin
      sh <= load;
    end else if (sel && sdr) begin
      sh <= {tdi, sh[W-1:1]};
    end
  end

endmodule

// File: rtl/jtag_reg_bank.sv
// Virtual-JTAG register bank between the Virtual JTAG instance and the MD5
// core: write registers, coded start/reset control, status and chunked
// result read-out, all clocked by tck.
module jtag_reg_bank
  import jtag_bank_pkg::*;
#(
  parameter int                IR_W       = IR_W_DEF,
  parameter int                DATA_W     = 32,
  parameter int                N_WR       = 4,
  parameter int                WR_IR_BASE = WR_IR_BASE_DEF,
  parameter int                CTRL_IR    = CTRL_IR_DEF,
  parameter int                CTRL_W     = 5,
  parameter logic [CTRL_W-1:0] START_CODE = CTRL_W'(START_CODE_DEF),
  parameter int                RST_LEN    = 16,
  parameter int                STAT_IR    = STAT_IR_DEF,
  parameter int                STAT_W     = 4,
  parameter int                RES_IR     = RES_IR_DEF,
  parameter int                RES_W      = 512,
  parameter int                CHUNK_W    = 8
) (
  input  logic                     tck,
  input  logic                     reset,
  input  logic                     tdi,
  input  logic [IR_W-1:0]          ir_in,
  input  logic                     cdr,
  input  logic                     sdr,
  input  logic                     udr,
  output logic                     tdo,
  output logic [N_WR*DATA_W-1:0]   wr_data,
  output logic [N_WR-1:0]          wr_valid,
  output logic                     core_reset,
  output logic                     core_ce,
  input  logic [STAT_W-1:0]        status_in,
  input  logic                     res_valid,
  input  logic [RES_W-1:0]         res_data,
  input  logic                     core_done
);

  localparam int N_CHUNK = RES_W / CHUNK_W;
  localparam int PTR_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam int CNT_W   = $clog2(RST_LEN + 1);
  localparam int SSH_W   = STAT_W + 2;

  logic [N_WR-1:0]   sel_wr;
  logic              sel_ctrl;
  logic              sel_stat;
  logic              sel_res;
  logic [DATA_W-1:0] wr_sh [N_WR];
  logic [CTRL_W-1:0] ctrl_sh;
  logic [CTRL_W-1:0] ctrl;
  logic [SSH_W-1:0]  stat_sh;
  logic [CHUNK_W-1:0] res_sh;
  logic [CHUNK_W-1:0] res_chunk;
  logic [RES_W-1:0]  res_buf;
  logic [PTR_W-1:0]  res_ptr;
  logic [STAT_W-1:0] stat_latched;
  logic              found_latched;
  logic              done_latched;
  run_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              start;
  logic              unused_sh_bits;

  assign sel_ctrl = (ir_in == IR_W'(CTRL_IR));
  assign sel_stat = (ir_in == IR_W'(STAT_IR));
  assign sel_res  = (ir_in == IR_W'(RES_IR));
  assign start    = udr && sel_ctrl && (ctrl_sh == START_CODE);

  assign res_chunk = res_buf[int'(res_ptr) * CHUNK_W +: CHUNK_W];

  // Upper status/result shift bits leave the bank only serially through tdo
  assign unused_sh_bits = ^{stat_sh[SSH_W-1:1], res_sh[CHUNK_W-1:1]};

  for (genvar k = 0; k < N_WR; k++) begin : g_wr
    assign sel_wr[k] = (ir_in == IR_W'(WR_IR_BASE + k));

    jtag_shift_reg #(.W(DATA_W)) u_wr_sh (
      .tck   (tck),
      .reset (reset),
      .tdi   (tdi),
      .sel   (sel_wr[k]),
      .cdr   (cdr),
      .sdr   (sdr),
      .load  (wr_data[k*DATA_W +: DATA_W]),
      .sh    (wr_sh[k])
    );
  end

  jtag_shift_reg #(.W(CTRL_W)) u_ctrl_sh (
    .tck   (tck),
    .reset (reset),
    .tdi   (tdi),
    .sel   (sel_ctrl),
    .cdr   (cdr),
    .sdr   (sdr),
    .load  (ctrl),
    .sh    (ctrl_sh)
  );

  jtag_shift_reg #(.W(SSH_W)) u_stat_sh (
    .tck   (tck),
    .reset (reset),
    .tdi   (tdi),
    .sel   (sel_stat),
    .cdr   (cdr),
    .sdr   (sdr),
    .load  ({found_latched, done_latched, stat_latched}),
    .sh    (stat_sh)
  );

  jtag_shift_reg #(.W(CHUNK_W)) u_res_sh (
    .tck   (tck),
    .reset (reset),
    .tdi   (tdi),
    .sel   (sel_res),
    .cdr   (cdr),
    .sdr   (sdr),
    .load  (res_chunk),
    .sh    (res_sh)
  );

  // Serial output: bit 0 of the addressed shift register, bypass otherwise
  always_comb begin
    tdo = tdi;
    for (int k = 0; k < N_WR; k++) begin
      if (sel_wr[k]) tdo = wr_sh[k][0];
    end
    if (sel_ctrl) tdo = ctrl_sh[0];
    if (sel_stat) tdo = stat_sh[0];
    if (sel_res)  tdo = res_sh[0];
  end

  // Shadow registers update on udr; the valid pulse lands with the new data
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      wr_data  <= '0;
      wr_valid <= '0;
    end else begin
      for (int k = 0; k < N_WR; k++) begin
        wr_valid[k] <= udr && sel_wr[k];
        if (udr && sel_wr[k]) wr_data[k*DATA_W +: DATA_W] <= wr_sh[k];
      end
    end
  end

  // Control register, run FSM, core reset timer, result/status latches
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      ctrl          <= '0;
      state         <= ST_IDLE;
      cnt           <= '0;
      core_reset    <= 1'b0;
      core_ce       <= 1'b0;
      found_latched <= 1'b0;
      done_latched  <= 1'b0;
      stat_latched  <= '0;
      res_buf       <= '0;
      res_ptr       <= '0;
    end else begin
      // A start code is consumed immediately so it cannot re-trigger
      if (udr && sel_ctrl) ctrl <= start ? '0 : ctrl_sh;

      if (start) begin
        state         <= ST_RESET;
        cnt           <= '0;
        core_reset    <= 1'b1;
        core_ce       <= 1'b1;
        found_latched <= 1'b0;
        done_latched  <= 1'b0;
        res_ptr       <= '0;
      end else begin
        if (cdr && sel_res) begin
          res_ptr <= (res_ptr == PTR_W'(N_CHUNK - 1)) ? '0 : res_ptr + 1'b1;
        end

        case (state)
          ST_RESET: begin
            if (cnt == CNT_W'(RST_LEN - 1)) begin
              core_reset <= 1'b0;
              state      <= ST_RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RUN: begin
            // A found result wins over exhaustion arriving in the same cycle
            if (res_valid) begin
              res_buf       <= res_data;
              stat_latched  <= status_in;
              found_latched <= 1'b1;
              done_latched  <= core_done;
              core_ce       <= 1'b0;
              state         <= ST_FINISHED;
            end else if (core_done) begin
              res_buf       <= '0;
              stat_latched  <= status_in;
              done_latched  <= 1'b1;
              core_ce       <= 1'b0;
              state         <= ST_FINISHED;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_reg_bank.sv
// Bench for jtag_reg_bank: randomized JTAG scans against a behavioural
// model of the register bank, run control and result read-out.
module tb_jtag_reg_bank;

  localparam int IR_W    = 4;
  localparam int DATA_W  = 32;
  localparam int N_WR    = 4;
  localparam int CTRL_W  = 5;
  localparam int STAT_W  = 4;
  localparam int RES_W   = 512;
  localparam int CHUNK_W = 8;
  localparam int RST_LEN = 16;
  localparam int N_CHUNK = RES_W / CHUNK_W;
  localparam int WR_IR_BASE = 6;
  localparam int CTRL_IR = 5;
  localparam int STAT_IR = 10;
  localparam int RES_IR  = 11;

  logic                   tck = 1'b0;
  logic                   reset;
  logic                   tdi;
  logic [IR_W-1:0]        ir_in;
  logic                   cdr, sdr, udr;
  logic                   tdo;
  logic [N_WR*DATA_W-1:0] wr_data;
  logic [N_WR-1:0]        wr_valid;
  logic                   core_reset, core_ce;
  logic [STAT_W-1:0]      status_in;
  logic                   res_valid;
  logic [RES_W-1:0]       res_data;
  logic                   core_done;

  jtag_reg_bank dut (
    .tck        (tck),
    .reset      (reset),
    .tdi        (tdi),
    .ir_in      (ir_in),
    .cdr        (cdr),
    .sdr        (sdr),
    .udr        (udr),
    .tdo        (tdo),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .core_reset (core_reset),
    .core_ce    (core_ce),
    .status_in  (status_in),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .core_done  (core_done)
  );

  always #5 tck = ~tck;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [DATA_W-1:0] m_wr [N_WR];
  logic              m_found, m_done, m_ce;
  logic [STAT_W-1:0] m_stat;
  logic [RES_W-1:0]  m_res;
  int                m_ptr;

  task automatic chk(input string tag, input logic [RES_W-1:0] got, input logic [RES_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_WR; k++) m_wr[k] = '0;
    m_found = 1'b0; m_done = 1'b0; m_ce = 1'b0;
    m_stat = '0; m_res = '0; m_ptr = 0;
  endtask

  function automatic logic [N_WR*DATA_W-1:0] exp_wr();
    logic [N_WR*DATA_W-1:0] v;
    for (int k = 0; k < N_WR; k++) v[k*DATA_W +: DATA_W] = m_wr[k];
    return v;
  endfunction

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  // Full DR scan: capture, n shift cycles (tdo sampled before each shift), update
  task automatic scan(input int ir, input logic [63:0] din, input int n, output logic [63:0] dout);
    ir_in = IR_W'(ir);
    cdr = 1'b1; step(); cdr = 1'b0;
    sdr = 1'b1;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tdi = din[i];
      #1;
      dout[i] = tdo;
      step();
    end
    sdr = 1'b0;
    udr = 1'b1; step(); udr = 1'b0;
  endtask

  task automatic write_reg(input int k, input logic [DATA_W-1:0] val);
    logic [63:0] d;
    scan(WR_IR_BASE + k, 64'(val), DATA_W, d);
    m_wr[k] = val;
    chk("wr_data", wr_data, exp_wr());
    chk("wr_valid_pulse", wr_valid, RES_W'(1) << k);
    step();
    chk("wr_valid_clear", wr_valid, '0);
    chk("wr_data_hold", wr_data, exp_wr());
  endtask

  task automatic start_scan(input logic [CTRL_W-1:0] code);
    logic [63:0] d;
    scan(CTRL_IR, 64'(code), CTRL_W, d);
    if (code == 5'b10101) begin
      m_found = 1'b0; m_done = 1'b0; m_ptr = 0; m_ce = 1'b1;
    end
  endtask

  // core_reset must be high for exactly RST_LEN observed cycles after the start scan
  task automatic chk_pulse();
    for (int c = 0; c < RST_LEN + 3; c++) begin
      chk($sformatf("core_reset_c%0d", c), core_reset, (c < RST_LEN) ? 1'b1 : 1'b0);
      chk($sformatf("core_ce_c%0d", c), core_ce, 1'b1);
      step();
    end
  endtask

  task automatic stat_scan();
    logic [63:0] d;
    scan(STAT_IR, 64'd0, STAT_W + 2, d);
    chk("status", d[STAT_W+1:0], {m_found, m_done, m_stat});
  endtask

  task automatic res_scan();
    logic [63:0] d;
    scan(RES_IR, 64'd0, CHUNK_W, d);
    chk($sformatf("res_chunk%0d", m_ptr), d[CHUNK_W-1:0], m_res[m_ptr*CHUNK_W +: CHUNK_W]);
    m_ptr = (m_ptr + 1) % N_CHUNK;
  endtask

  task automatic rand_res(output logic [RES_W-1:0] v);
    for (int i = 0; i < RES_W / 32; i++) v[i*32 +: 32] = $urandom;
  endtask

  // One cycle of core outcome; only the first outcome of a run is latched
  task automatic core_event(input logic rv, input logic cd, input logic [RES_W-1:0] data,
                            input logic [STAT_W-1:0] st);
    res_data = data; status_in = st; res_valid = rv; core_done = cd;
    step();
    res_valid = 1'b0; core_done = 1'b0;
    if (m_ce && (rv || cd)) begin
      if (rv) begin
        m_res = data; m_found = 1'b1; m_done = cd;
      end else begin
        m_res = '0; m_done = 1'b1;
      end
      m_stat = st;
      m_ce = 1'b0;
    end
    chk("core_ce_after_event", core_ce, m_ce);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RES_W-1:0] rd;
    int unmapped [9] = '{0, 1, 2, 3, 4, 12, 13, 14, 15};

    reset = 1'b1; tdi = 1'b0; ir_in = '0; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
    status_in = '0; res_valid = 1'b0; res_data = '0; core_done = 1'b0;
    model_reset();
    step(); step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_wr_data", wr_data, '0);
    chk("rst_wr_valid", wr_valid, '0);
    chk("rst_core_reset", core_reset, 1'b0);
    chk("rst_core_ce", core_ce, 1'b0);
    stat_scan();
    res_scan();

    // Directed write to register 2 (IR 8), then random writes
    write_reg(2, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) write_reg(int'($urandom_range(0, N_WR - 1)), $urandom);

    // Bypass on unmapped IR codes
    for (int i = 0; i < 6; i++) begin
      ir_in = IR_W'(unmapped[$urandom_range(0, 8)]);
      tdi = $urandom_range(0, 1);
      #1;
      chk("bypass", tdo, tdi);
      tdi = ~tdi;
      #1;
      chk("bypass_flip", tdo, tdi);
    end
    step();

    // Start a run, then a non-start control value has no effect
    start_scan(5'b10101);
    chk_pulse();
    start_scan(5'b00111);
    for (int c = 0; c < 4; c++) begin
      chk("noop_core_reset", core_reset, 1'b0);
      chk("noop_core_ce", core_ce, 1'b1);
      step();
    end

    // Found result: full read-out with wrap
    core_event(1'b1, 1'b0, 512'h0102, 4'd3);
    stat_scan();
    for (int i = 0; i < N_CHUNK + 1; i++) res_scan();
    rand_res(rd);
    core_event(1'b1, 1'b1, rd, 4'($urandom));
    stat_scan();

    // Found and done together
    start_scan(5'b10101);
    chk_pulse();
    rand_res(rd);
    core_event(1'b1, 1'b1, rd, 4'($urandom));
    stat_scan();
    res_scan();
    res_scan();

    // Exhausted without a result
    start_scan(5'b10101);
    chk_pulse();
    rand_res(rd);
    core_event(1'b0, 1'b1, rd, 4'($urandom));
    stat_scan();
    res_scan();
    res_scan();

    // Restart during RESET and during RUN
    start_scan(5'b10101);
    step(); step(); step();
    start_scan(5'b10101);
    chk_pulse();
    start_scan(5'b10101);
    chk_pulse();
    rand_res(rd);
    core_event(1'b1, 1'b0, rd, 4'($urandom));
    stat_scan();
    res_scan();

    // Asynchronous reset in the middle of a core reset pulse
    write_reg(0, $urandom | 32'h1);
    write_reg(1, $urandom | 32'h1);
    start_scan(5'b10101);
    step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_core_reset", core_reset, 1'b0);
    chk("async_core_ce", core_ce, 1'b0);
    chk("async_wr_data", wr_data, '0);
    chk("async_wr_valid", wr_valid, '0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_core_ce", core_ce, 1'b0);
    stat_scan();
    res_scan();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
